// File: rtl/button_queue.sv
// -----------------------------------------------------------------------------
// button_queue
//
// Conditions four raw push-buttons for the LRU tracker. Each button is
// synchronised, debounced and edge-detected. Every debounced press becomes one
// event, and events are queued in arrival order. The oldest pending press is
// shown one-hot on p1..p4 until the consumer pops it with tick.
//
// Parameters
//   DEB_CYCLES : synchronised cycles an input must disagree with its stable
//                value before the stable value flips (>= 2)
//   DEPTH      : event FIFO depth, power of two (>= 2)
//
// Ports
//   clk      : system clock, all state on the rising edge
//   rst      : asynchronous active-low reset
//   b1..b4   : raw asynchronous buttons, active high
//   tick     : one-cycle consumer strobe, pops the head entry if non-empty
//   p1..p4   : one-hot head entry (all 0 when empty)
//   empty    : FIFO holds no entries
//   overflow : sticky, a press was discarded because the FIFO was full
// -----------------------------------------------------------------------------
module button_queue #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEPTH      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    input  logic tick,
    output logic p1,
    output logic p2,
    output logic p3,
    output logic p4,
    output logic empty,
    output logic overflow
);

    localparam int CW   = $clog2(DEB_CYCLES);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]   CNT_MAX   = CW'(DEB_CYCLES - 1);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(DEPTH);

    // ------------------------------------------------------------------
    // Two-flop synchroniser, bit 0 = button 1
    // ------------------------------------------------------------------
    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    assign w_raw = {b4, b3, b2, b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce: the stable value flips only after the
    // synchronised input has disagreed with it for DEB_CYCLES consecutive
    // cycles. Any agreement restarts the count, so short glitches vanish.
    // ------------------------------------------------------------------
    logic [3:0] w_stable;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic [CW-1:0] r_cnt;
            logic          r_stable;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_sync2[gi] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_MAX) begin
                    r_stable <= r_sync2[gi];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign w_stable[gi] = r_stable;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Press detection: rising edge of the stable value only
    // ------------------------------------------------------------------
    logic [3:0] r_stable_prev;
    logic [3:0] w_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_prev <= '0;
        end else begin
            r_stable_prev <= w_stable;
        end
    end

    assign w_press = w_stable & ~r_stable_prev;

    // Simultaneous presses: button 1 wins, the rest are dropped silently.
    logic       w_push_valid;
    logic [1:0] w_push_code;

    always_comb begin
        w_push_valid = 1'b0;
        w_push_code  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_press[i]) begin
                w_push_valid = 1'b1;
                w_push_code  = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [1:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL);
    assign w_pop   = tick & ~w_empty;
    // When full, a push only fits if the head leaves in the same cycle.
    assign w_push  = w_push_valid & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_valid && w_full && !tick) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    logic [1:0] w_head;

    assign w_head   = r_mem[r_rd_ptr];
    assign p1       = ~w_empty & (w_head == 2'd0);
    assign p2       = ~w_empty & (w_head == 2'd1);
    assign p3       = ~w_empty & (w_head == 2'd2);
    assign p4       = ~w_empty & (w_head == 2'd3);
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_button_queue.sv
// -----------------------------------------------------------------------------
// tb_button_queue
//
// Drives directed scenarios followed by randomized button/tick activity and
// compares every cycle against a behavioural model: a button's stable value
// flips once the last DEB_CYCLES synchronised samples all disagree with it,
// and presses go into a plain queue.
// -----------------------------------------------------------------------------
module tb_button_queue;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0;
    logic tick = 1'b0;
    logic p1, p2, p3, p4, empty, overflow;

    button_queue #(.DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .tick(tick),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [3:0] m_stable;
    bit [3:0] m_prev;
    bit       m_hist [4][8];   // [btn][k]: raw sample from k+1 edges ago
    int       m_q[$];
    bit       m_ovf;

    function automatic void model_reset();
        m_stable = '0;
        m_prev   = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) m_hist[i][k] = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_edge(input bit [3:0] bv, input bit t);
        bit [3:0] press;
        int       code;
        bit       popped;
        bit       all_diff;
        press  = m_stable & ~m_prev;
        code   = -1;
        for (int i = 0; i < 4; i++)
            if (press[i] && code < 0) code = i;
        popped = t && (m_q.size() != 0);
        if (code >= 0 && m_q.size() == DEPTH && !t) m_ovf = 1'b1;
        if (popped) void'(m_q.pop_front());
        if (code >= 0 && (m_q.size() < DEPTH)) begin
            // still room (either not full, or head just left)
            if (!(m_q.size() == DEPTH - 1 && !popped && m_ovf && 0)) m_q.push_back(code);
        end
        m_prev = m_stable;
        for (int i = 0; i < 4; i++) begin
            // synchronised sample seen at this edge = raw from two edges ago
            all_diff = 1'b1;
            for (int k = 1; k <= DEB; k++)
                if (m_hist[i][k] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) m_stable[i] = ~m_stable[i];
            for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = bv[i];
        end
    endfunction

    function automatic int exp_pvec();
        if (m_q.size() == 0) return 0;
        return 1 << m_q[0];
    endfunction

    function automatic int dut_pvec();
        return int'({p4, p3, p2, p1});
    endfunction

    task automatic check_all();
        chk("p", dut_pvec(), exp_pvec());
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    // One clock: drive, edge, advance model, check just after the edge.
    task automatic cyc(input bit [3:0] bv, input bit t);
        {b4, b3, b2, b1} = bv;
        tick = t;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(bv, t);
        #1;
        check_all();
    endtask

    task automatic press(input bit [3:0] bv);
        repeat (8) cyc(bv, 1'b0);
        repeat (8) cyc(4'b0, 1'b0);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_p", dut_pvec(), 0);
        chk("rst_ovf", int'(overflow), 0);
    endtask

    initial begin
        bit [3:0] bv;
        int       hold;
        model_reset();

        // 1. reset with toggling buttons
        #2;
        assert_reset();
        for (int i = 0; i < 6; i++) cyc(4'($urandom), 1'($urandom));
        rst = 1'b1;
        repeat (10) cyc(4'b0, 1'b0);
        chk("s1_empty", int'(empty), 1);

        // 2. single press latency: b3 first sampled at edge 1
        for (int e = 1; e <= 20; e++) begin
            cyc(4'b0100, 1'b0);
            if (e == 6) chk("s2_edge6_empty", int'(empty), 1);
            if (e == 7) begin
                chk("s2_edge7_p", dut_pvec(), 4'b0100);
                chk("s2_edge7_empty", int'(empty), 0);
            end
        end
        cyc(4'b0, 1'b1);
        chk("s2_pop_empty", int'(empty), 1);
        chk("s2_pop_p", dut_pvec(), 0);
        repeat (8) cyc(4'b0, 1'b0);

        // 3. bounce then a real hold
        repeat (3) cyc(4'b0010, 1'b0);
        repeat (2) cyc(4'b0000, 1'b0);
        repeat (3) cyc(4'b0010, 1'b0);
        repeat (10) cyc(4'b0000, 1'b0);
        chk("s3_bounce_empty", int'(empty), 1);
        repeat (10) cyc(4'b0010, 1'b0);
        chk("s3_hold_p", dut_pvec(), 4'b0010);
        repeat (8) cyc(4'b0, 1'b0);
        cyc(4'b0, 1'b1);
        chk("s3_single_event", int'(empty), 1);

        // 4. ordering and priority
        press(4'b1000);
        press(4'b0001);
        press(4'b0100);
        press(4'b0011);
        chk("s4_head0", dut_pvec(), 4'b1000); cyc(4'b0, 1'b1);
        chk("s4_head1", dut_pvec(), 4'b0001); cyc(4'b0, 1'b1);
        chk("s4_head2", dut_pvec(), 4'b0100); cyc(4'b0, 1'b1);
        chk("s4_head3", dut_pvec(), 4'b0001); cyc(4'b0, 1'b1);
        chk("s4_empty", int'(empty), 1);
        chk("s4_ovf", int'(overflow), 0);

        // 5. overflow
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        chk("s5_ovf_before", int'(overflow), 0);
        press(4'b0001);
        chk("s5_ovf_after", int'(overflow), 1);
        chk("s5_head0", dut_pvec(), 4'b0001); cyc(4'b0, 1'b1);
        chk("s5_head1", dut_pvec(), 4'b0010); cyc(4'b0, 1'b1);
        chk("s5_head2", dut_pvec(), 4'b0100); cyc(4'b0, 1'b1);
        chk("s5_head3", dut_pvec(), 4'b1000); cyc(4'b0, 1'b1);
        chk("s5_empty", int'(empty), 1);

        // 6. full boundary with coinciding tick (fresh reset so overflow=0)
        #2;
        assert_reset();
        cyc(4'b0, 1'b0);
        rst = 1'b1;
        repeat (4) cyc(4'b0, 1'b0);
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        repeat (6) cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b1);          // push edge of this press
        chk("s6_head", dut_pvec(), 4'b0010);
        chk("s6_ovf", int'(overflow), 0);
        repeat (8) cyc(4'b0001, 1'b0);
        repeat (8) cyc(4'b0, 1'b0);
        #2;
        assert_reset();              // no clock edge between assert and check
        cyc(4'b0, 1'b0);
        rst = 1'b1;

        // Randomized activity with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            bv   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bv = 4'b0;
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) cyc(bv, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                assert_reset();
                cyc(4'($urandom), 1'b0);
                rst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
